// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage behind the ALU. ALU-only instructions go straight to
//   writeback with one cycle of latency. Loads and stores drive a single
//   outstanding request/ready data bus. Byte and half accesses are steered
//   onto their lanes, and load data is sign- or zero-extended.
//   Every accepted instruction produces one wb_valid pulse, including
//   aborted accesses, which are flagged with trap.
//
// Parameters
//   TIMEOUT_CYCLES : cycles mem_req may wait for mem_ready before the access
//                    is aborted with a trap (0 disables the timeout)
//
// Optional feature
//   LSU_MISALIGN_TRAP_EN : when defined, a misaligned half or word access
//                          traps without using the bus. When undefined, the
//                          address is aligned down to the access size.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   instruction handshake; a transfer
//                                       happens when both are high, and
//                                       in_ready is high only in IDLE
//   alu_result, rs2_data, funct3,
//   is_load, is_store, rd               instruction payload
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb                registered bus request, held until
//                                       mem_ready
//   mem_ready, mem_rdata                bus completion and read data
//   wb_valid, wb_we, wb_rd, wb_data,
//   trap                                one-cycle writeback pulse; all are
//                                       0 outside the pulse
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        trap
);

    typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] to_cnt;
    logic        op_load;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [1:0]  op_off;
    logic [4:0]  op_rd;

    logic        in_is_half;
    logic        in_is_word;
    logic        in_mem;
    logic [1:0]  in_off;
    logic [3:0]  in_strb;
    logic [31:0] in_wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        to_hit;

    assign in_ready = (state == IDLE);

    // Decode the incoming instruction. in_off is the byte lane of the
    // naturally aligned access; dropping the low address bits here is what
    // aligns misaligned accesses down when they are not trapped.
    always_comb begin
        in_is_half = (funct3[1:0] == 2'b01);
        in_is_word = funct3[1];
        in_mem     = is_load | is_store;
        if (in_is_word)
            in_off = 2'b00;
        else if (in_is_half)
            in_off = {alu_result[1], 1'b0};
        else
            in_off = alu_result[1:0];

        in_strb  = 4'b0000;
        in_wdata = 32'h0;
        if (!is_load) begin
            if (in_is_word) begin
                in_strb  = 4'b1111;
                in_wdata = rs2_data;
            end else if (in_is_half) begin
                in_strb  = 4'b0011 << in_off;
                in_wdata = {2{rs2_data[15:0]}};
            end else begin
                in_strb  = 4'b0001 << in_off;
                in_wdata = {4{rs2_data[7:0]}};
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic in_misal;
    always_comb begin
        in_misal = (in_is_half & alu_result[0]) | (in_is_word & (|alu_result[1:0]));
    end
`endif

    // Load lane extraction. The word case has op_off = 0, so shifted
    // equals mem_rdata.
    always_comb begin
        shifted = mem_rdata >> {op_off, 3'b000};
        case (op_size)
            2'b00:   load_val = {{24{~op_unsigned & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~op_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // A stall cycle that would bring the count up to TIMEOUT_CYCLES aborts
    // at this edge. This keeps mem_req high for exactly TIMEOUT_CYCLES cycles.
    assign to_hit = TO_EN && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            to_cnt      <= 32'h0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_wstrb   <= 4'b0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'h0;
            trap        <= 1'b0;
            op_load     <= 1'b0;
            op_size     <= 2'b0;
            op_unsigned <= 1'b0;
            op_off      <= 2'b0;
            op_rd       <= 5'd0;
        end else begin
            // Writeback outputs are a one-cycle pulse.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'h0;
            trap     <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_mem) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (rd != 5'd0);
                            wb_rd    <= rd;
                            wb_data  <= alu_result;
                        end
`ifdef LSU_MISALIGN_TRAP_EN
                        else if (in_misal) begin
                            wb_valid <= 1'b1;
                            trap     <= 1'b1;
                            wb_rd    <= rd;
                        end
`endif
                        else begin
                            state       <= MEM;
                            to_cnt      <= 32'h0;
                            mem_req     <= 1'b1;
                            mem_we      <= ~is_load;
                            mem_addr    <= {alu_result[31:2], 2'b00};
                            mem_wstrb   <= in_strb;
                            mem_wdata   <= in_wdata;
                            op_load     <= is_load;
                            op_size     <= funct3[1:0];
                            op_unsigned <= funct3[2];
                            op_off      <= in_off;
                            op_rd       <= rd;
                        end
                    end
                end
                MEM: begin
                    // mem_ready takes priority over a timeout in the same cycle.
                    if (mem_ready || to_hit) begin
                        state     <= IDLE;
                        to_cnt    <= 32'h0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wdata <= 32'h0;
                        mem_wstrb <= 4'b0;
                        wb_valid  <= 1'b1;
                        wb_rd     <= op_rd;
                        if (!mem_ready) begin
                            trap <= 1'b1;
                        end else if (op_load) begin
                            wb_we   <= (op_rd != 5'd0);
                            wb_data <= load_val;
                        end
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        trap;

    int checks   = 0;
    int failures = 0;

    logic [37:0] exp_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .rs2_data   (rs2_data),
        .funct3     (funct3),
        .is_load    (is_load),
        .is_store   (is_store),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .trap       (trap)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: access-size arithmetic
    function automatic int unsigned nbytes_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] addr, input logic [2:0] f3);
        int unsigned n;
        n = nbytes_of(f3);
        return addr - (addr % n);
    endfunction

    function automatic bit misaligned(input logic [31:0] addr, input logic [2:0] f3);
        return (addr % nbytes_of(f3)) != 0;
    endfunction

    task automatic model_bus(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rs2,
                             input bit st, output logic [31:0] e_addr, output logic [3:0] e_strb,
                             output logic [31:0] e_wdata);
        logic [31:0] base;
        int unsigned n;
        int unsigned off;
        n      = nbytes_of(f3);
        base   = base_of(addr, f3);
        off    = base % 4;
        e_addr = base - (base % 4);
        e_strb = 4'b0;
        e_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            e_strb[i] = st && (i >= off) && (i < off + n);
            e_wdata[8*i +: 8] = rs2[8*(i % n) +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3,
                                               input logic [31:0] rdata);
        int unsigned n;
        logic [31:0] base;
        logic [31:0] v;
        logic [31:0] mask;
        n    = nbytes_of(f3);
        base = base_of(addr, f3);
        v    = rdata >> (8 * (base % 4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Driver: one memory instruction with mem_ready arriving in the
    // delay-th request cycle (delay >= 1). Starts and ends just after a negedge.
    task automatic do_mem(input string tag, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [2:0] f3, input bit ld, input bit st, input logic [4:0] r,
                          input logic [31:0] rdata, input int delay);
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        bit          store;
        store = !ld;
        model_bus(addr, f3, rs2, store, e_addr, e_strb, e_wdata);
        chk({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_result = addr; rs2_data = rs2; funct3 = f3;
        is_load = ld; is_store = st; rd = r;
        @(negedge clk);
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (misaligned(addr, f3)) begin
            chk({tag, "_mis_req"},   {31'b0, mem_req},  32'd0);
            chk({tag, "_mis_wbv"},   {31'b0, wb_valid}, 32'd1);
            chk({tag, "_mis_trap"},  {31'b0, trap},     32'd1);
            chk({tag, "_mis_wbwe"},  {31'b0, wb_we},    32'd0);
            chk({tag, "_mis_ready"}, {31'b0, in_ready}, 32'd1);
            return;
        end
`endif
        for (int k = 1; k <= delay; k++) begin
            chk({tag, "_req"},      {31'b0, mem_req},  32'd1);
            chk({tag, "_we"},       {31'b0, mem_we},   {31'b0, store});
            chk({tag, "_addr"},     mem_addr,          e_addr);
            chk({tag, "_wstrb"},    {28'b0, mem_wstrb}, {28'b0, e_strb});
            if (store) chk({tag, "_wdata"}, mem_wdata, e_wdata);
            chk({tag, "_busy"},     {31'b0, in_ready}, 32'd0);
            chk({tag, "_no_wb"},    {31'b0, wb_valid}, 32'd0);
            mem_ready = (k == delay);
            mem_rdata = (k == delay) ? rdata : $urandom;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        chk({tag, "_req_drop"}, {31'b0, mem_req},  32'd0);
        chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
        chk({tag, "_trap"},     {31'b0, trap},     32'd0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        if (store) begin
            chk({tag, "_st_wbwe"},   {31'b0, wb_we}, 32'd0);
            chk({tag, "_st_wbdata"}, wb_data,        32'd0);
        end else begin
            chk({tag, "_ld_wbwe"},   {31'b0, wb_we}, {31'b0, (r != 5'd0)});
            chk({tag, "_ld_wbrd"},   {27'b0, wb_rd}, {27'b0, r});
            chk({tag, "_ld_data"},   wb_data,        model_load(addr, f3, rdata));
        end
    endtask

    // Driver: one pass-through op per cycle; the expected writeback goes
    // into exp_q and is popped one cycle later.
    task automatic pass_op(input logic [31:0] res, input logic [4:0] r);
        logic [37:0] e;
        in_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
        alu_result = res; rd = r; funct3 = 3'($urandom_range(0, 7)); rs2_data = $urandom;
        exp_q.push_back({(r != 5'd0), r, res});
        @(negedge clk);
        e = exp_q.pop_front();
        chk("pt_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("pt_wb_we",    {31'b0, wb_we},    {31'b0, e[37]});
        chk("pt_wb_rd",    {27'b0, wb_rd},    {27'b0, e[36:32]});
        chk("pt_wb_data",  wb_data,           e[31:0]);
        chk("pt_trap",     {31'b0, trap},     32'd0);
        chk("pt_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    logic [31:0] pt_res [3] = '{32'h1234, 32'hDEAD, 32'h1};
    logic [4:0]  pt_rd  [3] = '{5'd5, 5'd0, 5'd7};

    initial begin
        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); alu_result = $urandom; rs2_data = $urandom;
            funct3 = 3'($urandom); is_load = 1'($urandom); is_store = 1'($urandom);
            rd = 5'($urandom); mem_ready = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
        end
        chk("rst_in_ready", {31'b0, in_ready},  32'd1);
        chk("rst_mem_req",  {31'b0, mem_req},   32'd0);
        chk("rst_mem_we",   {31'b0, mem_we},    32'd0);
        chk("rst_mem_addr", mem_addr,           32'd0);
        chk("rst_wdata",    mem_wdata,          32'd0);
        chk("rst_wstrb",    {28'b0, mem_wstrb}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid},  32'd0);
        chk("rst_wb_we",    {31'b0, wb_we},     32'd0);
        chk("rst_wb_rd",    {27'b0, wb_rd},     32'd0);
        chk("rst_wb_data",  wb_data,            32'd0);
        chk("rst_trap",     {31'b0, trap},      32'd0);
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through: directed back-to-back ops, then random ones
        for (int i = 0; i < 3; i++) pass_op(pt_res[i], pt_rd[i]);
        for (int i = 0; i < 8; i++) pass_op($urandom, 5'($urandom_range(0, 31)));
        in_valid = 1'b0;
        @(negedge clk);
        chk("pt_idle_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("pt_idle_wb_data",  wb_data,           32'd0);

        // Directed memory ops
        do_mem("sb",  32'h1003, 32'h55AB, 3'b000, 1'b0, 1'b1, 5'd3, 32'h0, 3);
        do_mem("lb",  32'h2002, 32'h0, 3'b000, 1'b1, 1'b0, 5'd4, 32'h0080_0000, 1);
        do_mem("lbu", 32'h2002, 32'h0, 3'b100, 1'b1, 1'b0, 5'd4, 32'h0080_0000, 2);
        do_mem("lh",  32'h2002, 32'h0, 3'b001, 1'b1, 1'b0, 5'd6, 32'h8001_0000, 1);
        do_mem("lw",  32'h2000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 2);
        do_mem("lw_mis", 32'h1002, 32'h0, 3'b010, 1'b1, 1'b0, 5'd1, 32'h1357_9BDF, 1);
        do_mem("ld_st_both", 32'h2001, 32'hFFFF, 3'b000, 1'b1, 1'b1, 5'd2, 32'h0000_7F00, 1);

        // Random memory ops
        for (int i = 0; i < 20; i++) begin
            logic [2:0] f3;
            bit ld;
            bit st;
            f3 = 3'($urandom_range(0, 7));
            ld = 1'($urandom_range(0, 1));
            st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            do_mem("rnd", 32'h3000 + 32'($urandom_range(0, 63)), $urandom, f3, ld, st,
                   5'($urandom_range(0, 31)), $urandom, $urandom_range(1, 3));
        end

        // Timeout: mem_ready never arrives
        in_valid = 1'b1; alu_result = 32'h4000; funct3 = 3'b010; is_load = 1'b1; rd = 5'd8;
        @(negedge clk);
        in_valid = 1'b0; is_load = 1'b0;
        begin
            int req_cycles;
            req_cycles = 0;
            for (int k = 0; k < 10 && mem_req; k++) begin
                req_cycles++;
                @(negedge clk);
            end
            chk("to_req_cycles", 32'(req_cycles), 32'd4);
        end
        chk("to_req_drop", {31'b0, mem_req},  32'd0);
        chk("to_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("to_trap",     {31'b0, trap},     32'd1);
        chk("to_wb_we",    {31'b0, wb_we},    32'd0);
        chk("to_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk("to_trap_pulse", {31'b0, trap}, 32'd0);

        // Reset during MEM: mem_req falls asynchronously and no writeback follows
        in_valid = 1'b1; alu_result = 32'h5004; funct3 = 3'b010; is_store = 1'b1; rd = 5'd2;
        @(negedge clk);
        in_valid = 1'b0; is_store = 1'b0;
        chk("mr_req_before", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_async",  {31'b0, mem_req},  32'd0);
        chk("mr_in_ready",   {31'b0, in_ready}, 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mr_no_wb",      {31'b0, wb_valid}, 32'd0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_no_wb_after", {31'b0, wb_valid}, 32'd0);
        chk("mr_idle_req",    {31'b0, mem_req},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
